// File: rtl/izh_neuron_array_if.sv
// Bus interface of the Izhikevich neuron array: step control, model
// coefficients, current and state write ports, state readback and the
// ready/valid spike output. The array connects through the slave modport;
// whatever drives it (a controller or a bench) uses the master modport.
interface izh_neuron_array_if #(
    parameter int N  = 32,
    parameter int AW = 3
);
    logic          step_start;
    logic          step_busy;
    logic          step_done;
    logic [N-1:0]  cfg_a;
    logic [N-1:0]  cfg_b;
    logic [N-1:0]  cfg_c;
    logic [N-1:0]  cfg_d;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [N-1:0]  cur_data;
    logic          st_we;
    logic [AW-1:0] st_addr;
    logic [N-1:0]  st_v;
    logic [N-1:0]  st_w;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_v;
    logic [N-1:0]  rd_w;
    logic          spk_valid;
    logic          spk_ready;
    logic [AW-1:0] spk_idx;

    modport slave (
        input  step_start, cfg_a, cfg_b, cfg_c, cfg_d,
        input  cur_we, cur_addr, cur_data,
        input  st_we, st_addr, st_v, st_w,
        input  rd_addr, spk_ready,
        output step_busy, step_done, rd_v, rd_w, spk_valid, spk_idx
    );

    modport master (
        output step_start, cfg_a, cfg_b, cfg_c, cfg_d,
        output cur_we, cur_addr, cur_data,
        output st_we, st_addr, st_v, st_w,
        output rd_addr, spk_ready,
        input  step_busy, step_done, rd_v, rd_w, spk_valid, spk_idx
    );
endinterface

// File: rtl/izh_neuron_array.sv
// Time-multiplexed array of Izhikevich neurons. One integration step walks
// all neurons, one per clock, through a single shared fixed-point datapath.
// Spikes leave through a one-entry ready/valid register; a firing neuron that
// finds that register occupied and not draining stalls the walk.
// Optional feature macro IZH_SAT_EN: when defined, the v/w update sums
// saturate to the signed N-bit range; otherwise they wrap modulo 2^N.
module izh_neuron_array #(
    parameter int N           = 32,
    parameter int FRAC        = 16,
    parameter int NUM_NEURONS = 8,
    parameter int DT_SHIFT    = 3,
    parameter logic signed [N-1:0] V_TH   = N'(32 * (2 ** FRAC)),
    parameter logic signed [N-1:0] V_INIT = N'(-65 * (2 ** FRAC)),
    parameter logic signed [N-1:0] W_INIT = N'(-13 * (2 ** FRAC))
) (
    input logic               clk,
    input logic               rst_n,
    izh_neuron_array_if.slave bus
);
    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_NEURONS - 1);
    localparam logic signed [N-1:0] C_K004 = N'((4 * (2 ** FRAC) + 50) / 100);
    localparam logic signed [N-1:0] C_5    = N'(5 * (2 ** FRAC));
    localparam logic signed [N-1:0] C_140  = N'(140 * (2 ** FRAC));

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              r_state, w_nextState;
    logic [AW-1:0]       r_idx;
    logic signed [N-1:0] r_cfgA, r_cfgB, r_cfgC, r_cfgD;
    logic                r_stepDone;
    logic                r_spkValid;
    logic [AW-1:0]       r_spkIdx;
    logic [N-1:0]        r_rdV, r_rdW;
    logic signed [N-1:0] r_v   [NUM_NEURONS];
    logic signed [N-1:0] r_w   [NUM_NEURONS];
    logic signed [N-1:0] r_cur [NUM_NEURONS];

    logic signed [N-1:0] w_vk, w_wk, w_ik;
    logic signed [N-1:0] w_vInner, w_wInner, w_dv, w_dw;
    logic signed [N-1:0] w_vTmp, w_wTmp, w_wInc;
    logic                w_fire, w_hs, w_commit, w_doneEvt;

    // Fixed-point product keeping the integer-aligned middle N bits.
    function automatic logic signed [N-1:0] mulFx(input logic signed [N-1:0] a,
                                                  input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return N'(p >>> FRAC);
    endfunction

`ifdef IZH_SAT_EN
    // Signed add clamped to the N-bit range when the carry disagrees with the sign.
    function automatic logic signed [N-1:0] satAdd(input logic signed [N-1:0] a,
                                                   input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = {a[N-1], a} + {b[N-1], b};
        if (s[N] != s[N-1])
            return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        return s[N-1:0];
    endfunction
`endif

    assign w_vk = r_v[r_idx];
    assign w_wk = r_w[r_idx];
    assign w_ik = r_cur[r_idx];

    assign w_vInner = mulFx(mulFx(C_K004, w_vk), w_vk) + mulFx(C_5, w_vk) + C_140 - w_wk + w_ik;
    assign w_dv     = w_vInner >>> DT_SHIFT;
    assign w_wInner = mulFx(r_cfgA, mulFx(r_cfgB, w_vk) - w_wk);
    assign w_dw     = w_wInner >>> DT_SHIFT;

`ifdef IZH_SAT_EN
    assign w_vTmp = satAdd(w_vk, w_dv);
    assign w_wTmp = satAdd(w_wk, w_dw);
    assign w_wInc = satAdd(w_wk, r_cfgD);
`else
    assign w_vTmp = w_vk + w_dv;
    assign w_wTmp = w_wk + w_dw;
    assign w_wInc = w_wk + r_cfgD;
`endif

    assign w_fire = (w_vTmp > V_TH);
    assign w_hs   = r_spkValid && bus.spk_ready;

    // Next state: walk neurons in RUN, stalling a spike that cannot be queued,
    // and leave DONE only once the spike register has drained.
    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_doneEvt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.step_start)
                    w_nextState = RUN;
            end
            RUN: begin
                if (!(w_fire && r_spkValid && !bus.spk_ready)) begin
                    w_commit = 1'b1;
                    if (r_idx == LAST_IDX)
                        w_nextState = DONE;
                end
            end
            DONE: begin
                if (!r_spkValid || bus.spk_ready) begin
                    w_nextState = IDLE;
                    w_doneEvt   = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register, neuron index, coefficient latch and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_stepDone <= 1'b0;
            r_cfgA     <= '0;
            r_cfgB     <= '0;
            r_cfgC     <= '0;
            r_cfgD     <= '0;
        end else begin
            r_state    <= w_nextState;
            r_stepDone <= w_doneEvt;
            if (r_state == IDLE && bus.step_start) begin
                r_idx  <= '0;
                r_cfgA <= bus.cfg_a;
                r_cfgB <= bus.cfg_b;
                r_cfgC <= bus.cfg_c;
                r_cfgD <= bus.cfg_d;
            end else if (w_commit && r_idx != LAST_IDX) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    // Neuron v/w storage: committed updates in RUN, external loads only when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_v[i] <= V_INIT;
                r_w[i] <= W_INIT;
            end
        end else if (w_commit) begin
            r_v[r_idx] <= w_fire ? r_cfgC : w_vTmp;
            r_w[r_idx] <= w_fire ? w_wInc : w_wTmp;
        end else if (r_state == IDLE && bus.st_we && int'(bus.st_addr) < NUM_NEURONS) begin
            r_v[bus.st_addr] <= bus.st_v;
            r_w[bus.st_addr] <= bus.st_w;
        end
    end

    // Input currents, writable at any time and kept across steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++)
                r_cur[i] <= '0;
        end else if (bus.cur_we && int'(bus.cur_addr) < NUM_NEURONS) begin
            r_cur[bus.cur_addr] <= bus.cur_data;
        end
    end

    // One-entry spike register: drained by handshake, refilled by a committed firing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spkValid <= 1'b0;
            r_spkIdx   <= '0;
        end else begin
            if (w_hs)
                r_spkValid <= 1'b0;
            if (w_commit && w_fire) begin
                r_spkValid <= 1'b1;
                r_spkIdx   <= r_idx;
            end
        end
    end

    // Registered state readback; unpopulated addresses read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdV <= '0;
            r_rdW <= '0;
        end else if (int'(bus.rd_addr) < NUM_NEURONS) begin
            r_rdV <= r_v[bus.rd_addr];
            r_rdW <= r_w[bus.rd_addr];
        end else begin
            r_rdV <= '0;
            r_rdW <= '0;
        end
    end

    assign bus.step_busy = (r_state != IDLE);
    assign bus.step_done = r_stepDone;
    assign bus.spk_valid = r_spkValid;
    assign bus.spk_idx   = r_spkIdx;
    assign bus.rd_v      = r_rdV;
    assign bus.rd_w      = r_rdW;
endmodule

// File: doc/izh_neuron_array.md
IZH_NEURON_ARRAY -- requirements
Module: izh_neuron_array

Interface
- REQ-001: Parameters SHALL be:
  - N = 32: datapath width; signed fixed point with FRAC fraction bits.
  - FRAC = 16: fraction bits; 1.0 = 1<<FRAC.
  - NUM_NEURONS = 8: neurons held; index width AW = clog2(NUM_NEURONS), min 1.
  - DT_SHIFT = 3: dt = 2^-DT_SHIFT ms.
  - V_TH = 32.0: fire threshold, fixed point.
  - V_INIT = -65.0: reset value of v.
  - W_INIT = -13.0: reset value of w.
- REQ-002: Ports SHALL be:
  - clk, in, 1: rising-edge clock.
  - rst_n, in, 1: asynchronous active-low reset.
  - step_start, in, 1: begin one integration step over all neurons.
  - step_busy, out, 1: step in progress.
  - step_done, out, 1: one-cycle pulse when the step completes.
  - cfg_a, cfg_b, cfg_c, cfg_d, in, N each: model coefficients a, b, reset v (c), w increment (d).
  - cur_we, in, 1: current write enable.
  - cur_addr, in, AW: current write index.
  - cur_data, in, N: input current I for neuron cur_addr.
  - st_we, in, 1: state load enable, honoured only in IDLE.
  - st_addr, in, AW: state load index.
  - st_v, in, N: v value to load.
  - st_w, in, N: w value to load.
  - rd_addr, in, AW: state readback index.
  - rd_v, out, N: registered readback of v.
  - rd_w, out, N: registered readback of w.
  - spk_valid, out, 1: spike event valid.
  - spk_ready, in, 1: spike sink ready.
  - spk_idx, out, AW: index of the neuron that fired.

Function
- REQ-003: Per neuron, with all products truncated as (a*b)[FRAC+N-1:FRAC]:
  - v_tmp = v + ((0.04*v*v + 5*v + 140 - w + I) >>> DT_SHIFT).
  - w_tmp = w + ((cfg_a*(cfg_b*v - w)) >>> DT_SHIFT).
- REQ-004: If v_tmp > V_TH (signed compare): v <= cfg_c, w <= w + cfg_d, and a spike event is generated. Otherwise v <= v_tmp, w <= w_tmp.
- REQ-005: FSM states SHALL be IDLE, RUN and DONE.
  - IDLE -> RUN on step_start; the cfg_* inputs are latched on that edge.
  - RUN processes neuron k = 0..NUM_NEURONS-1, one per cycle.
  - After the last neuron, RUN -> DONE.
  - DONE -> IDLE in the same cycle the spike output is empty (spk_valid=0, or a handshake completes that cycle); step_done pulses on that transition.
- REQ-006: step_busy SHALL be 1 in RUN and DONE. step_start SHALL be ignored outside IDLE.
- REQ-007: With no stalls, step_done SHALL assert exactly NUM_NEURONS+1 cycles after the step_start edge.
- REQ-008: The spike output is a one-entry register.
  - It is loaded when a neuron fires.
  - It is cleared on spk_valid && spk_ready.
  - spk_valid and spk_idx SHALL stay stable until accepted.
- REQ-009: In RUN, when neuron k fires while spk_valid=1 && spk_ready=0:
  - k SHALL NOT be committed and the index SHALL NOT advance (stall).
  - A firing neuron coinciding with a handshake SHALL be committed that cycle.
- REQ-010: cur_we SHALL be accepted in any state.
  - A write to the neuron being processed in the same cycle: the old current is used.
  - Currents persist across steps.
- REQ-011: rd_v/rd_w SHALL reflect the state at rd_addr one cycle after rd_addr is sampled.
- REQ-012: Out-of-range addresses (>= NUM_NEURONS) on cur_*, st_* or rd_* SHALL be ignored; reads of such an address return 0.

Reset
- REQ-013: On rst_n=0, regardless of state including mid-step:
  - FSM goes to IDLE; step_busy, step_done, spk_valid = 0; spk_idx = 0.
  - rd_v, rd_w = 0.
  - All v = V_INIT, all w = W_INIT, all currents = 0.
  - Latched cfg = 0.
- REQ-014: Reset release SHALL be synchronous to clk; the first step_start SHALL be accepted on the first edge after release.

Configuration
- REQ-015: Macro IZH_SAT_EN.
  - Defined: v_tmp, w_tmp and w + cfg_d SHALL saturate to [-2^(N-1), 2^(N-1)-1].
  - Undefined: these results wrap modulo 2^N.

Verification
- REQ-016: Reset, then read neuron 3 -> rd_v = 0xFFBF0000, rd_w = 0xFFF30000; spk_valid = 0.
- REQ-017: st_v = 30.0, st_w = 0, I = 0, cfg_c = -65.0, cfg_d = 8.0, spk_ready = 1, one step -> spk_idx = k; v = 0xFFBF0000, w = 0x00080000.
- REQ-018: All 8 neurons preset to fire, spk_ready held 0 for 5 cycles after the first spike -> exactly 8 spikes, indices 0..7 in order, none lost; step_done delayed 5 cycles.
- REQ-019: rst_n pulsed low at cycle 3 of RUN -> all state returns to reset values, step_busy = 0, no step_done.
- REQ-020: w = 0x7FFF0000, cfg_d = 8.0, neuron fires -> w = 0x7FFFFFFF with IZH_SAT_EN; 0x80070000 without.
